// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel synchronise, debounce and mode-selected edge detection with sticky flags and a saturating event count
module multi_edge_detector #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overflow,
  output logic [CNT_W-1:0] event_cnt
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = CNT_W + 6;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync, filt, done, hit;
  logic [DW-1:0] deb [WIDTH];
  logic [5:0] pop;
  logic [SW-1:0] sum;
  assign sync = sync_q[SYNC_STAGES-1];
  always_comb begin
    done = '0;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) done[i] = sync[i] != filt[i] && deb[i] == DW'(DEB_CYCLES - 1);
    hit = mode == 2'b00 ? done & sync : mode == 2'b01 ? done & ~sync : mode == 2'b10 ? done : '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + 6'(hit[i]);
    sum = (cnt_clr ? '0 : SW'(event_cnt)) + SW'(pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) deb[i] <= '0;
      filt <= '0;
      pulse <= '0;
      pending <= '0;
      overflow <= '0;
      event_cnt <= '0;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < WIDTH; i++) deb[i] <= (sync[i] == filt[i] || done[i]) ? '0 : deb[i] + DW'(1);
      // an accepted transition always flips the held level
      filt <= filt ^ done;
      pulse <= hit;
      pending <= hit | (pending & ~clr);
      overflow <= (hit & pending & ~clr) | (overflow & ~clr);
      event_cnt <= |sum[SW-1:CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: directed stimulus checked every cycle against a run-length behavioural model
module tb_multi_edge_detector;
  localparam int W = 8, SS = 2, DC = 4;
  logic clk = 0, reset_n = 0, cnt_clr = 0;
  logic [W-1:0] in = '0, clr = '0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] pulse, pending, overflow, pulse2, pending2, overflow2;
  logic [15:0] event_cnt;
  logic [1:0] cnt2;
  int checks = 0, errors = 0;
  int exp2 [5] = '{1, 2, 3, 3, 3};
  multi_edge_detector dut (.clk(clk), .reset_n(reset_n), .in(in), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
    .pulse(pulse), .pending(pending), .overflow(overflow), .event_cnt(event_cnt));
  multi_edge_detector #(.CNT_W(2)) dut2 (.clk(clk), .reset_n(reset_n), .in(in), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
    .pulse(pulse2), .pending(pending2), .overflow(overflow2), .event_cnt(cnt2));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: input delayed SS samples, accepted after DC consecutive differing cycles
  logic [W-1:0] hist [SS];
  logic [W-1:0] m_filt, m_pulse, m_pend, m_ovf, m_s, m_ev;
  int run [W];
  int m_cnt, m_cnt2;
  task automatic model_reset();
    for (int k = 0; k < SS; k++) hist[k] = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
    m_filt = '0; m_pulse = '0; m_pend = '0; m_ovf = '0; m_cnt = 0; m_cnt2 = 0;
  endtask
  task automatic model_step();
    m_s = hist[SS-1];
    m_ev = '0;
    for (int i = 0; i < W; i++) begin
      if (m_s[i] != m_filt[i]) begin
        run[i]++;
        if (run[i] == DC) begin
          run[i] = 0;
          m_filt[i] = m_s[i];
          m_ev[i] = mode == 2'b10 || (mode == 2'b00 && m_s[i]) || (mode == 2'b01 && !m_s[i]);
        end
      end else run[i] = 0;
    end
    m_cnt = (cnt_clr ? 0 : m_cnt) + $countones(m_ev);
    if (m_cnt > 65535) m_cnt = 65535;
    m_cnt2 = (cnt_clr ? 0 : m_cnt2) + $countones(m_ev);
    if (m_cnt2 > 3) m_cnt2 = 3;
    m_ovf = (m_ev & m_pend & ~clr) | (m_ovf & ~clr);
    m_pend = m_ev | (m_pend & ~clr);
    m_pulse = m_ev;
    for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = in;
  endtask
  always @(posedge clk or negedge reset_n)
    if (!reset_n) model_reset();
    else model_step();
  always @(negedge clk) begin
    chk("pulse", pulse, m_pulse);
    chk("pending", pending, m_pend);
    chk("overflow", overflow, m_ovf);
    chk("event_cnt", event_cnt, m_cnt);
    chk("event_cnt_w2", cnt2, m_cnt2);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pulse", pulse, 0);
    chk("rst_pending", pending, 0);
    chk("rst_cnt", event_cnt, 0);
    reset_n = 1;
    repeat (3) @(negedge clk);
    in[0] = 1;
    repeat (5) @(negedge clk);
    chk("lat_early", pulse[0], 0);
    @(negedge clk);
    chk("lat_pulse", pulse[0], 1);
    chk("lat_pending", pending[0], 1);
    chk("lat_cnt", event_cnt, 1);
    @(negedge clk);
    chk("lat_one_cycle", pulse[0], 0);
    in[3] = 1;
    repeat (3) @(negedge clk);
    in[3] = 0;
    repeat (10) @(negedge clk);
    chk("glitch_cnt", event_cnt, 1);
    chk("glitch_pending", pending[3], 0);
    mode = 2'b10;
    in[1] = 1;
    repeat (10) @(negedge clk);
    in[1] = 0;
    repeat (10) @(negedge clk);
    chk("both_pending", pending[1], 1);
    chk("both_overflow", overflow[1], 1);
    chk("both_cnt", event_cnt, 3);
    clr = 8'h02;
    @(negedge clk);
    clr = '0;
    chk("clr_pending", pending[1], 0);
    chk("clr_overflow", overflow[1], 0);
    mode = 2'b00;
    in = '0;
    repeat (10) @(negedge clk);
    in = 8'hFF;
    repeat (5) @(negedge clk);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    chk("all_pulse", pulse, 8'hFF);
    chk("all_cnt_clr", event_cnt, 8);
    in = '0;
    repeat (10) @(negedge clk);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    chk("w2_cleared", cnt2, 0);
    for (int k = 0; k < 5; k++) begin
      in[4] = 1;
      repeat (6) @(negedge clk);
      chk("w2_sat", cnt2, exp2[k]);
      in[4] = 0;
      repeat (8) @(negedge clk);
    end
    chk("w16_five", event_cnt, 5);
    mode = 2'b11;
    in[2] = 1;
    repeat (10) @(negedge clk);
    chk("mode11_cnt", event_cnt, 5);
    mode = 2'b01;
    in[2] = 0;
    repeat (6) @(negedge clk);
    chk("mode01_pulse", pulse[2], 1);
    chk("mode01_cnt", event_cnt, 6);
    mode = 2'b00;
    in[5] = 1;
    repeat (3) @(negedge clk);
    #1 reset_n = 0;
    #1;
    chk("async_pulse", pulse, 0);
    chk("async_pending", pending, 0);
    chk("async_overflow", overflow, 0);
    chk("async_cnt", event_cnt, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_early", pulse, 0);
    @(negedge clk);
    chk("post_rst_pulse", pulse, 8'h20);
    chk("post_rst_cnt", event_cnt, 1);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of independent input channels, legal range 1..32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser flop depth per channel, legal minimum 2.
REQ-003 The block SHALL have parameter DEB_CYCLES, default 4: consecutive cycles a new level must persist before acceptance, legal range 1..255.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the event counter.
REQ-005 Port clk SHALL be an input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-007 Port in SHALL be an input, WIDTH bits: asynchronous raw channel inputs.
REQ-008 Port mode SHALL be an input, 2 bits: 00 rising, 01 falling, 10 both edges, 11 detection disabled; it applies to all channels.
REQ-009 Port clr SHALL be an input, WIDTH bits: per-channel write-1-to-clear for pending and overflow.
REQ-010 Port cnt_clr SHALL be an input, 1 bit: synchronous clear of event_cnt.
REQ-011 Port pulse SHALL be an output, WIDTH bits, registered: one-cycle strobe per detected edge.
REQ-012 Port pending SHALL be an output, WIDTH bits, registered: sticky flag per channel meaning an edge was detected.
REQ-013 Port overflow SHALL be an output, WIDTH bits, registered: sticky flag per channel meaning an edge was detected while pending was already set.
REQ-014 Port event_cnt SHALL be an output, CNT_W bits, registered: saturating total of detected edges.

Function
REQ-015 Each channel SHALL pass in[i] through SYNC_STAGES flops; the last stage is sync[i].
REQ-016 Each channel SHALL hold an accepted level filt[i] and a debounce counter deb[i] of width clog2(DEB_CYCLES+1).
REQ-017 When sync[i]==filt[i], deb[i] SHALL load 0 on the next edge.
REQ-018 When sync[i]!=filt[i] and deb[i]<DEB_CYCLES-1, deb[i] SHALL increment.
REQ-019 When sync[i]!=filt[i] and deb[i]==DEB_CYCLES-1, filt[i] SHALL load sync[i] and deb[i] SHALL load 0; this update is the channel transition.
REQ-020 A sync[i] excursion shorter than DEB_CYCLES cycles SHALL produce no transition.
REQ-021 pulse[i] SHALL be 1 for exactly the one cycle following a transition that matches mode: 0->1 for mode 00, 1->0 for mode 01, either for mode 10, never for mode 11.
REQ-022 Latency SHALL be SYNC_STAGES+DEB_CYCLES rising edges from the first edge that samples a stable new in[i] to pulse[i] high, which is 6 edges at default parameters.
REQ-023 filt and deb SHALL track in every mode, including 11; a mode change SHALL affect only transitions occurring on or after the edge at which the new mode is sampled.
REQ-024 pending[i] SHALL set on the same edge pulse[i] rises; clr[i] SHALL clear it; if set and clear coincide, set SHALL win.
REQ-025 overflow[i] SHALL set when pulse[i] rises while pending[i] is 1 and clr[i] is 0; clr[i] SHALL clear it; if set and clear coincide, set SHALL win.
REQ-026 event_cnt SHALL add the popcount of the newly asserting pulse bits each cycle and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 When cnt_clr coincides with events, event_cnt SHALL load the popcount of those events, so clear applies first and the add follows.
REQ-028 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each pulse and each be counted.

Reset
REQ-029 While reset_n=0, all synchroniser flops, filt, deb, pulse, pending, overflow and event_cnt SHALL be 0 asynchronously.
REQ-030 After reset release, an input held at 1 SHALL be treated as a 0->1 transition and SHALL pulse after the REQ-022 latency in modes 00 and 10.
REQ-031 Asserting reset_n=0 mid-debounce SHALL discard the partial count with no pulse.

Verification
REQ-032 Defaults, mode=00, in[0] 0->1 held: pulse[0]=1 for one cycle at edge 6, pending[0]=1, event_cnt=1.
REQ-033 Defaults, mode=00, in[3] high for 3 cycles then low: no pulse, filt[3] stays 0, event_cnt unchanged.
REQ-034 Defaults, mode=10, in[1] rises then falls 10 cycles later: two pulses; pending[1]=1 and overflow[1]=1 after the second pulse; clr[1]=1 -> both 0.
REQ-035 Defaults, in=8'hFF from 0 in one cycle with mode=00: all 8 pulses on the same cycle, event_cnt=8; cnt_clr coincident with that cycle -> event_cnt=8.
REQ-036 CNT_W=2, five rising edges: event_cnt reads 1,2,3,3,3.
REQ-037 Defaults, mode=11 with in[2] rising, then mode=01 and in[2] falling: no pulse for the rise, one pulse for the fall; reset_n=0 mid-debounce -> all outputs 0 immediately.
